// File: rtl/thread_dispatcher.sv
// Job dispatcher for the multithreaded core: queues job tags, starts free hardware threads
// in round-robin order and reports each finished job with the thread that ran it.
module thread_dispatcher #(
    parameter int NUM_THREADS  = 8,
    parameter int TID_WIDTH    = 3,
    parameter int JOB_ID_WIDTH = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [JOB_ID_WIDTH-1:0] job_id,
    output logic [NUM_THREADS-1:0]  start_thread,
    input  logic [NUM_THREADS-1:0]  thread_done,
    output logic                    cmpl_valid,
    output logic [JOB_ID_WIDTH-1:0] cmpl_id,
    output logic [TID_WIDTH-1:0]    cmpl_tid,
    output logic [15:0]             jobs_completed,
    output logic                    idle,
    output logic                    err_spurious
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [JOB_ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [JOB_ID_WIDTH-1:0] tag_mem  [NUM_THREADS];
    logic [PTR_W:0]          wr_ptr_reg, rd_ptr_reg;
    logic [NUM_THREADS-1:0]  alloc_reg, pending_reg, alloc_next, pending_next;
    logic [TID_WIDTH-1:0]    rr_ptr_reg;
    logic                    fifo_empty, fifo_full, push, dispatch, grant_found, report;
    logic [TID_WIDTH-1:0]    grant, report_tid;
    logic [NUM_THREADS-1:0]  grant_mask, report_mask;
    logic [JOB_ID_WIDTH-1:0] fifo_head;
    logic [TID_WIDTH-1:0]    cand [NUM_THREADS];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign job_ready  = !fifo_full && !reset;
    assign push       = job_valid && job_ready;
    assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign dispatch   = en && !fifo_empty && grant_found;
    assign idle       = fifo_empty && (alloc_reg == '0) && (pending_reg == '0);

    // Scanning offsets high-to-low leaves the nearest free thread at or after rr_ptr.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int o = NUM_THREADS - 1; o >= 0; o--) begin
            if (!alloc_reg[cand[o]]) begin
                grant       = cand[o];
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        report     = 1'b0;
        report_tid = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                report     = 1'b1;
                report_tid = TID_WIDTH'(i);
            end
        end
    end

    assign grant_mask  = dispatch ? (NUM_THREADS'(1) << grant) : '0;
    assign report_mask = report ? (NUM_THREADS'(1) << report_tid) : '0;

    generate
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
            assign cand[gi] = TID_WIDTH'((int'(rr_ptr_reg) + gi) % NUM_THREADS);
            // The reported thread frees up this cycle, so a done on it is not re-captured.
            assign alloc_next[gi]   = (alloc_reg[gi] && !report_mask[gi]) || grant_mask[gi];
            assign pending_next[gi] = (pending_reg[gi] || (thread_done[gi] && alloc_reg[gi]))
                                      && !report_mask[gi];

            always_ff @(posedge clk) begin
                if (dispatch && (grant == TID_WIDTH'(gi)))
                    tag_mem[gi] <= fifo_head;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= job_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            alloc_reg      <= '0;
            pending_reg    <= '0;
            rr_ptr_reg     <= '0;
            start_thread   <= '0;
            cmpl_valid     <= 1'b0;
            cmpl_id        <= '0;
            cmpl_tid       <= '0;
            jobs_completed <= '0;
            err_spurious   <= 1'b0;
        end else begin
            alloc_reg    <= alloc_next;
            pending_reg  <= pending_next;
            start_thread <= grant_mask;
            cmpl_valid   <= report;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (dispatch) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rr_ptr_reg <= (grant == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : grant + 1'b1;
            end
            if (report) begin
                cmpl_id        <= tag_mem[report_tid];
                cmpl_tid       <= report_tid;
                jobs_completed <= jobs_completed + 16'd1;
            end
            if (|(thread_done & ~alloc_reg))
                err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_thread_dispatcher.sv
// Directed bench for thread_dispatcher; completions are checked against a scoreboard
// filled whenever the bench raises thread_done.
module tb_thread_dispatcher;
    logic        clk = 1'b0;
    logic        reset, en, job_valid, job_ready;
    logic [7:0]  job_id;
    logic [7:0]  start_thread, thread_done;
    logic        cmpl_valid, idle, err_spurious;
    logic [7:0]  cmpl_id;
    logic [2:0]  cmpl_tid;
    logic [15:0] jobs_completed;

    typedef struct packed {
        logic [7:0] id;
        logic [2:0] tid;
    } cmpl_t;

    cmpl_t       sb_q [$];
    cmpl_t       sb_e;
    logic [15:0] exp_completed = '0;
    int          checks = 0;
    int          errors = 0;

    thread_dispatcher dut (
        .clk(clk), .reset(reset), .en(en), .job_valid(job_valid), .job_ready(job_ready),
        .job_id(job_id), .start_thread(start_thread), .thread_done(thread_done),
        .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_tid(cmpl_tid),
        .jobs_completed(jobs_completed), .idle(idle), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise thread_done for one cycle; expected reports queue in ascending thread order.
    task automatic done_pulse(input logic [7:0] mask, input logic [7:0] tags [8]);
        for (int t = 0; t < 8; t++)
            if (mask[t]) sb_q.push_back('{id: tags[t], tid: 3'(t)});
        thread_done = mask;
        tick();
        thread_done = '0;
    endtask

    task automatic sb_drained(input string tag);
        check(tag, 32'(sb_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && cmpl_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_cmpl", 32'(cmpl_valid), 0);
            end else begin
                sb_e = sb_q.pop_front();
                exp_completed = exp_completed + 16'd1;
                check("sb_cmpl_id", 32'(cmpl_id), 32'(sb_e.id));
                check("sb_cmpl_tid", 32'(cmpl_tid), 32'(sb_e.tid));
                check("sb_jobs_completed", 32'(jobs_completed), 32'(exp_completed));
            end
        end
    end

    initial begin
        logic [7:0] tags [8];
        for (int t = 0; t < 8; t++) tags[t] = '0;
        reset = 1'b1; en = 1'b1; job_valid = 1'b0; job_id = '0; thread_done = '0;

        // 1: reset state, single job latency and completion
        tick(); tick();
        check("ready_in_reset", 32'(job_ready), 0);
        reset = 1'b0;
        tick();
        check("rst_start", 32'(start_thread), 0);
        check("rst_cmpl_valid", 32'(cmpl_valid), 0);
        check("rst_count", 32'(jobs_completed), 0);
        check("rst_err", 32'(err_spurious), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_ready", 32'(job_ready), 1);
        job_valid = 1'b1; job_id = 8'h2A;
        tick();
        job_valid = 1'b0;
        check("t1_start_n1", 32'(start_thread), 0);
        tick();
        check("t1_start_n2", 32'(start_thread), 32'h01);
        tags[0] = 8'h2A;
        check("t1_busy", 32'(idle), 0);
        tick();
        check("t1_start_n3", 32'(start_thread), 0);
        done_pulse(8'h01, tags);
        tick();
        check("t1_cmpl_valid", 32'(cmpl_valid), 1);
        check("t1_cmpl_id", 32'(cmpl_id), 32'h2A);
        check("t1_cmpl_tid", 32'(cmpl_tid), 0);
        check("t1_count", 32'(jobs_completed), 1);
        tick();
        check("t1_cmpl_off", 32'(cmpl_valid), 0);
        check("t1_idle", 32'(idle), 1);
        sb_drained("t1_drained");

        // 2: 13 back-to-back jobs, round-robin fill, backpressure, thread reuse
        sb_q.delete(); exp_completed = '0;
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        for (int i = 0; i < 12; i++) begin
            job_valid = 1'b1; job_id = 8'(8'h10 + i);
            check($sformatf("t2_ready_%0d", i), 32'(job_ready), 1);
            tick();
            check($sformatf("t2_start_%0d", i), 32'(start_thread),
                  (i >= 1 && i <= 8) ? (32'h1 << (i - 1)) : 32'h0);
        end
        for (int t = 0; t < 8; t++) tags[t] = 8'(8'h10 + t);
        job_id = 8'h1C;
        check("t2_full_ready", 32'(job_ready), 0);
        done_pulse(8'h01, tags);
        job_valid = 1'b1;
        check("t2_ready_held", 32'(job_ready), 0);
        tick();
        check("t2_no_early_reuse", 32'(start_thread), 0);
        check("t2_ready_before_pop", 32'(job_ready), 0);
        tick();
        check("t2_reuse_thread0", 32'(start_thread), 32'h01);
        check("t2_ready_after_pop", 32'(job_ready), 1);
        tick();
        job_valid = 1'b0;
        check("t2_refull", 32'(job_ready), 0);
        tick();
        sb_drained("t2_drained");

        // 3: simultaneous dones on threads 2 and 5 drain in ascending order
        sb_q.delete(); exp_completed = '0;
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin
            job_valid = 1'b1; job_id = 8'(8'h30 + i);
            tick();
        end
        job_valid = 1'b0;
        for (int t = 0; t < 6; t++) tags[t] = 8'(8'h30 + t);
        tick(); tick();
        done_pulse(8'h24, tags);
        tick();
        check("t3_first_valid", 32'(cmpl_valid), 1);
        check("t3_first_tid", 32'(cmpl_tid), 2);
        tick();
        check("t3_second_valid", 32'(cmpl_valid), 1);
        check("t3_second_tid", 32'(cmpl_tid), 5);
        tick();
        check("t3_drain_done", 32'(cmpl_valid), 0);
        check("t3_count", 32'(jobs_completed), 2);

        // 4: en low holds dispatch; en high resumes round-robin from thread 6
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            job_valid = 1'b1; job_id = 8'(8'h40 + i);
            check($sformatf("t4_ready_%0d", i), 32'(job_ready), 1);
            tick();
            check($sformatf("t4_hold_%0d", i), 32'(start_thread), 0);
        end
        job_valid = 1'b0;
        tick();
        check("t4_hold_end", 32'(start_thread), 0);
        check("t4_ready_end", 32'(job_ready), 1);
        en = 1'b1;
        tick();
        check("t4_start_a", 32'(start_thread), 32'h40);
        tick();
        check("t4_start_b", 32'(start_thread), 32'h80);
        tick();
        check("t4_start_c", 32'(start_thread), 32'h04);
        tick();
        check("t4_start_off", 32'(start_thread), 0);
        tags[6] = 8'h40; tags[7] = 8'h41; tags[2] = 8'h42;

        // 5: free thread 3, then a spurious done on it
        done_pulse(8'h08, tags);
        tick();
        check("t5_cmpl_tid", 32'(cmpl_tid), 3);
        check("t5_err_before", 32'(err_spurious), 0);
        check("t5_count_before", 32'(jobs_completed), 3);
        thread_done = 8'h08;
        tick();
        thread_done = '0;
        check("t5_err_set", 32'(err_spurious), 1);
        tick();
        check("t5_no_cmpl", 32'(cmpl_valid), 0);
        check("t5_count_same", 32'(jobs_completed), 3);
        tick();
        check("t5_err_sticky", 32'(err_spurious), 1);
        sb_drained("t5_drained");

        // 6: reset with busy threads and queued jobs
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            job_valid = 1'b1; job_id = 8'(8'h50 + i);
            tick();
        end
        job_valid = 1'b0;
        check("t6_busy", 32'(idle), 0);
        sb_q.delete(); exp_completed = '0;
        reset = 1'b1;
        tick();
        check("t6_start", 32'(start_thread), 0);
        check("t6_cmpl_valid", 32'(cmpl_valid), 0);
        check("t6_cmpl_id", 32'(cmpl_id), 0);
        check("t6_cmpl_tid", 32'(cmpl_tid), 0);
        check("t6_count", 32'(jobs_completed), 0);
        check("t6_err", 32'(err_spurious), 0);
        check("t6_idle", 32'(idle), 1);
        check("t6_ready_in_reset", 32'(job_ready), 0);
        reset = 1'b0; en = 1'b1;
        tick();
        check("t6_ready", 32'(job_ready), 1);
        tick();
        check("t6_dropped_a", 32'(start_thread), 0);
        tick();
        check("t6_dropped_b", 32'(start_thread), 0);
        check("t6_idle_after", 32'(idle), 1);
        sb_drained("t6_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
